// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   mult_state_t : FSM encoding (IDLE, BUSY, DONE)
//   prod_width() : product width for a given operand width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
// Operands are reduced to unsigned magnitudes at accept time, so the datapath
// is a single 2*WIDTH adder. The sign is restored when the product is written.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand handshake (a, b, is_signed sampled on accept)
//   out_valid/out_ready  : product handshake
//   product              : 2*WIDTH result, two's complement when is_signed was 1
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           is_signed,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [prod_width(WIDTH)-1:0]   product
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t      state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;     // multiplicand, shifted left each step
  logic [WIDTH-1:0] mplier_q, mplier_d;   // multiplier, shifted right each step
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_sum;

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    prod_d      = prod_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = PW'(a_mag);
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Negating zero yields zero, so no negative-zero case exists.
          prod_d      = neg_q ? -acc_sum : acc_sum;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign product   = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
  import mult_pkg::*;

  localparam int W  = 8;
  localparam int PW = prod_width(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic          is_signed;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product)
  );

  always #5 clk = ~clk;

  // Reference: plain integer multiply, truncated to the product width.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    longint p;
    logic [63:0] pv;
    if (s) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'({1'b0, x}) * longint'({1'b0, y});
    pv = p;
    return pv[PW-1:0];
  endfunction

  // Drives one accept, then waits (bounded) for out_valid. Returns the product
  // seen when out_valid rises and the edges counted since the accept edge.
  // Leaves the block in DONE; the caller decides when to handshake.
  task automatic start_and_wait(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                output logic [PW-1:0] got, output int lat);
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; is_signed = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);  // must not matter now
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = product;
  endtask

  // Completes the output handshake with out_ready high for one edge.
  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b product=%h, want 1 0 0000",
               in_ready, out_valid, product);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_unsigned_sweep();
    logic [PW-1:0] got;
    int lat;
    for (int i = 1; i <= 10; i++) begin
      for (int j = 1; j <= 10; j++) begin
        start_and_wait(W'(i), W'(j), 1'b0, got, lat);
        checks++;
        if (got !== PW'(i * j)) begin
          errors++;
          $display("FAIL sweep %0d*%0d: got %h want %h", i, j, got, PW'(i * j));
        end
        checks++;
        if (lat !== W) begin
          errors++;
          $display("FAIL sweep_latency %0d*%0d: got %0d edges want %0d", i, j, lat, W);
        end
        drain();
      end
    end
  endtask

  task automatic test_signed_mix();
    logic [W-1:0]  xs [6] = '{8'hFD, 8'h80, 8'h80, 8'h00, 8'hFF, 8'hFF};
    logic [W-1:0]  ys [6] = '{8'h05, 8'h80, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
    logic          ss [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [PW-1:0] ex [6] = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0000, 16'hFE01, 16'h0001};
    logic [PW-1:0] got;
    int lat;
    for (int k = 0; k < 6; k++) begin
      start_and_wait(xs[k], ys[k], ss[k], got, lat);
      checks++;
      if (got !== ex[k] || lat !== W) begin
        errors++;
        $display("FAIL signed_mix[%0d] %h*%h s=%b: got %h lat %0d want %h lat %0d",
                 k, xs[k], ys[k], ss[k], got, lat, ex[k], W);
      end
      drain();
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] got, exp;
    logic [W-1:0]  x, y;
    logic          s;
    int lat;
    for (int k = 0; k < 40; k++) begin
      x = W'($urandom); y = W'($urandom); s = 1'($urandom);
      exp = ref_mul(x, y, s);
      start_and_wait(x, y, s, got, lat);
      checks++;
      if (got !== exp || lat !== W) begin
        errors++;
        $display("FAIL random %h*%h s=%b: got %h lat %0d want %h lat %0d",
                 x, y, s, got, lat, exp, W);
      end
      drain();
    end
  endtask

  task automatic test_back_pressure();
    logic [PW-1:0] got;
    int lat;
    out_ready = 1'b0;
    start_and_wait(8'd10, 8'd10, 1'b0, got, lat);
    checks++;
    if (got !== 16'h0064 || lat !== W) begin
      errors++;
      $display("FAIL bp_result: got %h lat %0d want 0064 lat %0d", got, lat, W);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (product !== 16'h0064 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: product=%h out_valid=%b in_ready=%b, want 0064 1 0",
                 c, product, out_valid, in_ready);
      end
    end
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'h0064) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b product=%h, want 0 1 0064",
               out_valid, in_ready, product);
    end
  endtask

  task automatic test_ignored_input();
    int pulses = 0;
    logic prev = 1'b0;
    logic [PW-1:0] last = '0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 8'd3; b = 8'd4; is_signed = 1'b0;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; a = 8'd7; b = 8'd7;   // during BUSY: must be dropped
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid && !prev) begin
        pulses++;
        last = product;
      end
      prev = out_valid;
    end
    checks++;
    if (pulses !== 1 || last !== 16'h000C) begin
      errors++;
      $display("FAIL ignored_input: pulses=%0d product=%h, want 1 000C", pulses, last);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [PW-1:0] got;
    int lat;
    bit seen = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 8'd9; b = 8'd9; is_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; a = 8'd5; b = 8'd5;   // not accepted under reset
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: in_ready=%b out_valid=%b product=%h, want 1 0 0000",
               in_ready, out_valid, product);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: activity seen=%b, want 0", seen);
    end
    start_and_wait(8'd2, 8'd2, 1'b0, got, lat);
    checks++;
    if (got !== 16'h0004 || lat !== W) begin
      errors++;
      $display("FAIL after_reset 2*2: got %h lat %0d want 0004 lat %0d", got, lat, W);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_unsigned_sweep();
    test_signed_mix();
    test_random();
    test_back_pressure();
    test_ignored_input();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
